// File: rtl/ktms_sintr_pkg.sv
// Shared definitions for the response-stage synchronous interrupt sequencer.
package ktms_sintr_pkg;

   // Sequencer states: accept, issue interrupt, await completion, back off, forward
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_BKOFF = 3'd3,
      ST_OUT   = 3'd4
   } sintr_state_e;

   // Completion code reported by the PSL for a successful interrupt
   localparam logic [1:0] INTR_RC_OK = 2'd0;

   // Idle cycles inserted between interrupt retries
   localparam int SINTR_BKOFF_DFLT = 16;

endpackage

// File: rtl/capi_parcheck.sv
// Odd-parity checker: flags an error when a qualified word plus its parity bit has even weight.
module capi_parcheck #(
   parameter int width = 64
) (
   input  logic             i_v,
   input  logic [width-1:0] i_d,
   input  logic             i_p,
   output logic             o_error
);

   // A good word has an odd number of ones across data and parity
   always_comb begin
      o_error = i_v & ~(^{i_p, i_d});
   end

endmodule

// File: rtl/ktms_afu_rtry_ctr.sv
// Retry counter and backoff down-counter used between interrupt attempts.
module ktms_afu_rtry_ctr
   import ktms_sintr_pkg::*;
#(
   parameter int bkoff_cycles = SINTR_BKOFF_DFLT,
   parameter int rtry_width   = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_rtry_clr,
   input  logic                  i_rtry_inc,
   input  logic [rtry_width-1:0] i_rtry_cfg,
   input  logic                  i_bkoff_ld,
   input  logic                  i_bkoff_dec,
   output logic                  o_rtry_lim,
   output logic                  o_bkoff_zero
);

   localparam int BW = (bkoff_cycles > 1) ? $clog2(bkoff_cycles) : 1;
   localparam logic [BW-1:0] BKOFF_LD = BW'(bkoff_cycles - 1);

   logic [rtry_width-1:0] rtry_cnt_q, rtry_cnt_d;
   logic [BW-1:0]         bkoff_cnt_q, bkoff_cnt_d;

   // Next values: clear/increment for retries, load/decrement for backoff
   always_comb begin
      rtry_cnt_d  = rtry_cnt_q;
      bkoff_cnt_d = bkoff_cnt_q;
      if (i_rtry_clr) begin
         rtry_cnt_d = '0;
      end else if (i_rtry_inc) begin
         rtry_cnt_d = rtry_cnt_q + 1'b1;
      end
      if (i_bkoff_ld) begin
         bkoff_cnt_d = BKOFF_LD;
      end else if (i_bkoff_dec && (bkoff_cnt_q != '0)) begin
         bkoff_cnt_d = bkoff_cnt_q - 1'b1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rtry_cnt_q  <= '0;
         bkoff_cnt_q <= '0;
      end else begin
         rtry_cnt_q  <= rtry_cnt_d;
         bkoff_cnt_q <= bkoff_cnt_d;
      end
   end

   // The live retry limit is compared against the count of retries already made
   assign o_rtry_lim   = (rtry_cnt_q >= i_rtry_cfg);
   assign o_bkoff_zero = (bkoff_cnt_q == '0);

endmodule

// File: rtl/ktms_afu_sintr.sv
// Response-stage interrupt sequencer: optionally raises a synchronous interrupt
// (with retry/backoff) for each response, then forwards it tagged with the outcome.
module ktms_afu_sintr
   import ktms_sintr_pkg::*;
#(
   parameter int ctxtid_width  = 10,
   parameter int ea_width      = 65,
   parameter int tstag_width   = 1,
   parameter int aux_width     = 1,
   parameter int sintrid_width = 4,
   parameter int bkoff_cycles  = SINTR_BKOFF_DFLT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [5:0]               i_rtry_cfg,

   input  logic                     i_rsp_v,
   output logic                     i_rsp_r,
   input  logic [ctxtid_width-1:0]  i_rsp_ctxt,
   input  logic [ea_width-1:0]      i_rsp_ea,
   input  logic [tstag_width-1:0]   i_rsp_tstag,
   input  logic [aux_width-1:0]     i_rsp_aux,
   input  logic                     i_rsp_ec,
   input  logic                     i_rsp_nocmpl,
   input  logic                     i_rsp_sintr_v,
   input  logic [sintrid_width-1:0] i_rsp_sintr_id,

   output logic                     o_intr_v,
   input  logic                     o_intr_r,
   output logic [ctxtid_width-1:0]  o_intr_ctxt,
   output logic [sintrid_width-1:0] o_intr_id,

   input  logic                     i_intr_done_v,
   output logic                     i_intr_done_r,
   input  logic [1:0]               i_intr_done_rc,

   output logic                     o_rsp_v,
   input  logic                     o_rsp_r,
   output logic [ctxtid_width-1:0]  o_rsp_ctxt,
   output logic [ea_width-1:0]      o_rsp_ea,
   output logic [tstag_width-1:0]   o_rsp_tstag,
   output logic [aux_width-1:0]     o_rsp_aux,
   output logic                     o_rsp_ec,
   output logic                     o_rsp_nocmpl,
   output logic                     o_rsp_intr_fail,

   output logic [1:0]               o_dbg_cnt_inc,
   output logic                     o_perror
);

   sintr_state_e state_q, state_d;

   logic [ctxtid_width-1:0]  ctxt_q;
   logic [ea_width-1:0]      ea_q;
   logic [tstag_width-1:0]   tstag_q;
   logic [aux_width-1:0]     aux_q;
   logic                     ec_q;
   logic                     nocmpl_q;
   logic [sintrid_width-1:0] sintr_id_q;
   logic                     intr_fail_q, intr_fail_d;
   logic [1:0]               dbg_q, dbg_d;
   logic                     perr_sticky_q, perr_sticky_d;
   logic                     perror_q;

   logic capture;
   logic rtry_inc;
   logic bkoff_ld;
   logic bkoff_dec;
   logic rtry_lim;
   logic bkoff_zero;
   logic par_err;

   // A new response may enter when idle, or when the held one drains this cycle
   assign i_rsp_r       = (state_q == ST_IDLE) | ((state_q == ST_OUT) & o_rsp_r);
   assign o_intr_v      = (state_q == ST_REQ);
   assign i_intr_done_r = (state_q == ST_WAIT);
   assign o_rsp_v       = (state_q == ST_OUT);

   assign o_intr_ctxt     = ctxt_q;
   assign o_intr_id       = sintr_id_q;
   assign o_rsp_ctxt      = ctxt_q;
   assign o_rsp_ea        = ea_q;
   assign o_rsp_tstag     = tstag_q;
   assign o_rsp_aux       = aux_q;
   assign o_rsp_ec        = ec_q;
   assign o_rsp_nocmpl    = nocmpl_q;
   assign o_rsp_intr_fail = intr_fail_q;
   assign o_dbg_cnt_inc   = dbg_q;
   assign o_perror        = perror_q;

   // Sequencer next-state, counter controls and outcome bookkeeping
   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      rtry_inc    = 1'b0;
      bkoff_ld    = 1'b0;
      bkoff_dec   = 1'b0;
      intr_fail_d = intr_fail_q;
      dbg_d       = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (i_rsp_v) begin
               capture = 1'b1;
               state_d = i_rsp_sintr_v ? ST_REQ : ST_OUT;
            end
         end
         ST_REQ: begin
            if (o_intr_r) begin
               dbg_d[0] = 1'b1;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_intr_done_v) begin
               if (i_intr_done_rc == INTR_RC_OK) begin
                  intr_fail_d = 1'b0;
                  state_d     = ST_OUT;
               end else if (!rtry_lim) begin
                  rtry_inc = 1'b1;
                  bkoff_ld = 1'b1;
                  state_d  = ST_BKOFF;
               end else begin
                  dbg_d[1]    = 1'b1;
                  intr_fail_d = 1'b1;
                  state_d     = ST_OUT;
               end
            end
         end
         ST_BKOFF: begin
            if (bkoff_zero) begin
               state_d = ST_REQ;
            end else begin
               bkoff_dec = 1'b1;
            end
         end
         ST_OUT: begin
            if (o_rsp_r) begin
               if (i_rsp_v) begin
                  capture = 1'b1;
                  state_d = i_rsp_sintr_v ? ST_REQ : ST_OUT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (capture) begin
         intr_fail_d = 1'b0;
      end
   end

   // The parity error is sticky until reset
   always_comb begin
      perr_sticky_d = perr_sticky_q | par_err;
   end

   // State, holding register and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ctxt_q        <= '0;
         ea_q          <= '0;
         tstag_q       <= '0;
         aux_q         <= '0;
         ec_q          <= 1'b0;
         nocmpl_q      <= 1'b0;
         sintr_id_q    <= '0;
         intr_fail_q   <= 1'b0;
         dbg_q         <= 2'b00;
         perr_sticky_q <= 1'b0;
         perror_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         intr_fail_q   <= intr_fail_d;
         dbg_q         <= dbg_d;
         perr_sticky_q <= perr_sticky_d;
         perror_q      <= perr_sticky_q;
         if (capture) begin
            ctxt_q     <= i_rsp_ctxt;
            ea_q       <= i_rsp_ea;
            tstag_q    <= i_rsp_tstag;
            aux_q      <= i_rsp_aux;
            ec_q       <= i_rsp_ec;
            nocmpl_q   <= i_rsp_nocmpl;
            sintr_id_q <= i_rsp_sintr_id;
         end
      end
   end

   ktms_afu_rtry_ctr #(
      .bkoff_cycles (bkoff_cycles),
      .rtry_width   (6)
   ) u_rtry_ctr (
      .clk          (clk),
      .reset        (reset),
      .i_rtry_clr   (capture),
      .i_rtry_inc   (rtry_inc),
      .i_rtry_cfg   (i_rtry_cfg),
      .i_bkoff_ld   (bkoff_ld),
      .i_bkoff_dec  (bkoff_dec),
      .o_rtry_lim   (rtry_lim),
      .o_bkoff_zero (bkoff_zero)
   );

   capi_parcheck #(
      .width (ea_width - 1)
   ) u_ea_parcheck (
      .i_v     (capture),
      .i_d     (i_rsp_ea[ea_width-2:0]),
      .i_p     (i_rsp_ea[ea_width-1]),
      .o_error (par_err)
   );

endmodule

// File: tb/tb_ktms_afu_sintr.sv
// Directed, table-driven bench for the response-stage interrupt sequencer.
module tb_ktms_afu_sintr;

   logic        clk;
   logic        reset;
   logic [5:0]  i_rtry_cfg;
   logic        i_rsp_v;
   logic        i_rsp_r;
   logic [9:0]  i_rsp_ctxt;
   logic [64:0] i_rsp_ea;
   logic [0:0]  i_rsp_tstag;
   logic [0:0]  i_rsp_aux;
   logic        i_rsp_ec;
   logic        i_rsp_nocmpl;
   logic        i_rsp_sintr_v;
   logic [3:0]  i_rsp_sintr_id;
   logic        o_intr_v;
   logic        o_intr_r;
   logic [9:0]  o_intr_ctxt;
   logic [3:0]  o_intr_id;
   logic        i_intr_done_v;
   logic        i_intr_done_r;
   logic [1:0]  i_intr_done_rc;
   logic        o_rsp_v;
   logic        o_rsp_r;
   logic [9:0]  o_rsp_ctxt;
   logic [64:0] o_rsp_ea;
   logic [0:0]  o_rsp_tstag;
   logic [0:0]  o_rsp_aux;
   logic        o_rsp_ec;
   logic        o_rsp_nocmpl;
   logic        o_rsp_intr_fail;
   logic [1:0]  o_dbg_cnt_inc;
   logic        o_perror;

   typedef struct {
      logic [9:0]  ctxt;
      logic [63:0] ead;
      logic        sintr;
      logic [3:0]  id;
      logic [5:0]  cfg;
      logic [7:0]  rc;
      int          nRc;
      int          expIntr;
      logic        expFail;
      int          expDbg1;
   } vec_t;

   int nChecks = 0;
   int nFails  = 0;

   int cyc = 0;
   int intrCnt = 0;
   int dbg0Cnt = 0;
   int dbg1Cnt = 0;
   int lastIntrCyc = 0;
   int lastGap = 0;
   logic [3:0] lastIntrId = '0;
   logic [9:0] lastIntrCtxt = '0;

   vec_t vecs [7];

   ktms_afu_sintr dut (
      .clk             (clk),
      .reset           (reset),
      .i_rtry_cfg      (i_rtry_cfg),
      .i_rsp_v         (i_rsp_v),
      .i_rsp_r         (i_rsp_r),
      .i_rsp_ctxt      (i_rsp_ctxt),
      .i_rsp_ea        (i_rsp_ea),
      .i_rsp_tstag     (i_rsp_tstag),
      .i_rsp_aux       (i_rsp_aux),
      .i_rsp_ec        (i_rsp_ec),
      .i_rsp_nocmpl    (i_rsp_nocmpl),
      .i_rsp_sintr_v   (i_rsp_sintr_v),
      .i_rsp_sintr_id  (i_rsp_sintr_id),
      .o_intr_v        (o_intr_v),
      .o_intr_r        (o_intr_r),
      .o_intr_ctxt     (o_intr_ctxt),
      .o_intr_id       (o_intr_id),
      .i_intr_done_v   (i_intr_done_v),
      .i_intr_done_r   (i_intr_done_r),
      .i_intr_done_rc  (i_intr_done_rc),
      .o_rsp_v         (o_rsp_v),
      .o_rsp_r         (o_rsp_r),
      .o_rsp_ctxt      (o_rsp_ctxt),
      .o_rsp_ea        (o_rsp_ea),
      .o_rsp_tstag     (o_rsp_tstag),
      .o_rsp_aux       (o_rsp_aux),
      .o_rsp_ec        (o_rsp_ec),
      .o_rsp_nocmpl    (o_rsp_nocmpl),
      .o_rsp_intr_fail (o_rsp_intr_fail),
      .o_dbg_cnt_inc   (o_dbg_cnt_inc),
      .o_perror        (o_perror)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to time interrupt spacing
   always @(posedge clk) cyc = cyc + 1;

   // Observe interrupt handshakes and debug pulses mid-cycle
   always @(negedge clk) begin
      if (o_intr_v && o_intr_r) begin
         lastGap      = cyc - lastIntrCyc;
         lastIntrCyc  = cyc;
         lastIntrId   = o_intr_id;
         lastIntrCtxt = o_intr_ctxt;
         intrCnt      = intrCnt + 1;
      end
      if (o_dbg_cnt_inc[0]) dbg0Cnt = dbg0Cnt + 1;
      if (o_dbg_cnt_inc[1]) dbg1Cnt = dbg1Cnt + 1;
   end

   function automatic logic [64:0] goodEa(input logic [63:0] d);
      return {~(^d), d};
   endfunction

   function automatic logic [64:0] badEa(input logic [63:0] d);
      return {^d, d};
   endfunction

   function automatic vec_t mkVec(input logic [9:0] c, input logic [63:0] d, input logic s,
                                  input logic [3:0] id, input logic [5:0] cfg, input logic [7:0] rc,
                                  input int nRc, input int eI, input logic eF, input int eD1);
      vec_t v;
      v.ctxt = c; v.ead = d; v.sintr = s; v.id = id; v.cfg = cfg; v.rc = rc;
      v.nRc = nRc; v.expIntr = eI; v.expFail = eF; v.expDbg1 = eD1;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks = nChecks + 1;
      if (act !== exp) begin
         nFails = nFails + 1;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic driveRsp(input logic [9:0] c, input logic [64:0] ea, input logic s, input logic [3:0] id);
      i_rsp_v        = 1'b1;
      i_rsp_ctxt     = c;
      i_rsp_ea       = ea;
      i_rsp_tstag    = c[0];
      i_rsp_aux      = c[1];
      i_rsp_ec       = c[2];
      i_rsp_nocmpl   = c[3];
      i_rsp_sintr_v  = s;
      i_rsp_sintr_id = id;
   endtask

   // Run one response through the sequencer, answering interrupts from the vector's rc list
   task automatic applyStimulus(input vec_t v, input int idx);
      int  i0, d0, d1, rcIdx, lat;
      bit  seen;
      logic [78:0] expPay;
      i0 = intrCnt; d0 = dbg0Cnt; d1 = dbg1Cnt; rcIdx = 0; lat = 0; seen = 0;
      expPay = {v.ctxt, goodEa(v.ead), v.ctxt[0], v.ctxt[1], v.ctxt[2], v.ctxt[3]};
      i_rtry_cfg = v.cfg;
      o_rsp_r    = 1'b1;
      o_intr_r   = 1'b1;
      driveRsp(v.ctxt, goodEa(v.ead), v.sintr, v.id);
      i_intr_done_v  = (v.nRc > 0);
      i_intr_done_rc = v.rc[1:0];
      stepCycle();
      i_rsp_v = 1'b0;
      while (!seen && lat < 400) begin
         if (o_rsp_v) begin
            seen = 1'b1;
            checkOutput($sformatf("v%0d payload", idx), 128'({o_rsp_ctxt, o_rsp_ea, o_rsp_tstag, o_rsp_aux, o_rsp_ec, o_rsp_nocmpl}), 128'(expPay));
            checkOutput($sformatf("v%0d intr_fail", idx), 128'(o_rsp_intr_fail), 128'(v.expFail));
            if (!v.sintr) checkOutput($sformatf("v%0d bypass latency", idx), 128'(lat), 128'(0));
         end else begin
            if (i_intr_done_v && i_intr_done_r) rcIdx = rcIdx + 1;
            stepCycle();
            lat = lat + 1;
            i_intr_done_v = (rcIdx < v.nRc);
            if (rcIdx < v.nRc) i_intr_done_rc = v.rc[2*rcIdx +: 2];
         end
      end
      checkOutput($sformatf("v%0d rsp seen", idx), 128'(seen), 128'(1));
      stepCycle();
      i_intr_done_v = 1'b0;
      checkOutput($sformatf("v%0d intr count", idx), 128'(intrCnt - i0), 128'(v.expIntr));
      checkOutput($sformatf("v%0d dbg0 count", idx), 128'(dbg0Cnt - d0), 128'(v.expIntr));
      checkOutput($sformatf("v%0d dbg1 count", idx), 128'(dbg1Cnt - d1), 128'(v.expDbg1));
      checkOutput($sformatf("v%0d done consumed", idx), 128'(rcIdx), 128'(v.nRc));
      if (v.expIntr > 0) begin
         checkOutput($sformatf("v%0d intr id", idx), 128'(lastIntrId), 128'(v.id));
         checkOutput($sformatf("v%0d intr ctxt", idx), 128'(lastIntrCtxt), 128'(v.ctxt));
      end
      checkOutput($sformatf("v%0d idle after", idx), 128'(o_rsp_v), 128'(0));
   endtask

   // Everything an async reset must force, checked together
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " o_rsp_v"}, 128'(o_rsp_v), 128'(0));
      checkOutput({tag, " o_intr_v"}, 128'(o_intr_v), 128'(0));
      checkOutput({tag, " done_r"}, 128'(i_intr_done_r), 128'(0));
      checkOutput({tag, " intr_fail"}, 128'(o_rsp_intr_fail), 128'(0));
      checkOutput({tag, " dbg"}, 128'(o_dbg_cnt_inc), 128'(0));
      checkOutput({tag, " perror"}, 128'(o_perror), 128'(0));
      checkOutput({tag, " payload"}, 128'({o_rsp_ctxt, o_rsp_ea}), 128'(0));
   endtask

   logic [9:0]  bpCtxt [4];
   logic [63:0] bpData;

   initial begin
      reset = 1'b0; i_rtry_cfg = '0; i_rsp_v = 1'b0; i_rsp_ctxt = '0; i_rsp_ea = '0;
      i_rsp_tstag = '0; i_rsp_aux = '0; i_rsp_ec = 1'b0; i_rsp_nocmpl = 1'b0;
      i_rsp_sintr_v = 1'b0; i_rsp_sintr_id = '0; o_intr_r = 1'b0; i_intr_done_v = 1'b0;
      i_intr_done_rc = '0; o_rsp_r = 1'b0;

      vecs[0] = mkVec(10'h2A5, 64'h0123_4567_89AB_CDEF, 1'b0, 4'h0, 6'd0, 8'h00, 0, 0, 1'b0, 0);
      vecs[1] = mkVec(10'd10,  64'hDEAD_BEEF_0000_0001, 1'b1, 4'h3, 6'd0, 8'h00, 1, 1, 1'b0, 0);
      vecs[2] = mkVec(10'h155, 64'h0000_0000_0000_0001, 1'b1, 4'h7, 6'd2, 8'h01, 2, 2, 1'b0, 0);
      vecs[3] = mkVec(10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'hA, 6'd0, 8'h02, 1, 1, 1'b1, 1);
      vecs[4] = mkVec(10'h001, 64'h8000_0000_0000_0000, 1'b1, 4'hF, 6'd3, 8'h55, 4, 4, 1'b1, 1);
      vecs[5] = mkVec(10'h200, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, 4'h1, 6'd3, 8'h0B, 3, 3, 1'b0, 0);
      vecs[6] = mkVec(10'h0F0, 64'h1111_2222_3333_4444, 1'b0, 4'h9, 6'd5, 8'h00, 0, 0, 1'b0, 0);

      repeat (2) stepCycle();
      checkResetOutputs("reset");
      reset = 1'b1;
      stepCycle();
      checkOutput("rsp_r after reset", 128'(i_rsp_r), 128'(1));

      // Directed table
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], i);
         if (i == 2) checkOutput("retry spacing", 128'(lastGap), 128'(18));
      end

      // Back-to-back bypass stream at full rate
      begin
         int i0;
         i0 = intrCnt;
         o_rsp_r = 1'b1;
         bpCtxt[0] = 10'h011; bpCtxt[1] = 10'h122; bpCtxt[2] = 10'h233; bpCtxt[3] = 10'h344;
         for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
               bpData = {54'd0, bpCtxt[k]};
               driveRsp(bpCtxt[k], goodEa(bpData), 1'b0, 4'h0);
            end else begin
               i_rsp_v = 1'b0;
            end
            #1;
            if (k > 0) begin
               checkOutput($sformatf("stream %0d valid", k), 128'(o_rsp_v), 128'(1));
               checkOutput($sformatf("stream %0d ctxt", k), 128'(o_rsp_ctxt), 128'(bpCtxt[k-1]));
               checkOutput($sformatf("stream %0d fail", k), 128'(o_rsp_intr_fail), 128'(0));
            end
            stepCycle();
         end
         checkOutput("stream drained", 128'(o_rsp_v), 128'(0));
         checkOutput("stream no intr", 128'(intrCnt - i0), 128'(0));
      end

      // Backpressure with a bad-parity EA
      begin
         logic [64:0] badE;
         bpData = 64'h0F0F_0000_1234_5678;
         badE   = badEa(bpData);
         o_rsp_r = 1'b0;
         driveRsp(10'h2C3, badE, 1'b0, 4'h0);
         stepCycle();
         driveRsp(10'h0AA, goodEa(64'h5), 1'b0, 4'h0);
         for (int k = 0; k < 10; k++) begin
            #1;
            checkOutput($sformatf("bp %0d valid", k), 128'(o_rsp_v), 128'(1));
            checkOutput($sformatf("bp %0d ea", k), 128'({o_rsp_ctxt, o_rsp_ea}), 128'({10'h2C3, badE}));
            checkOutput($sformatf("bp %0d rsp_r", k), 128'(i_rsp_r), 128'(0));
            if (k == 1) checkOutput("perror set", 128'(o_perror), 128'(1));
            stepCycle();
         end
         i_rsp_v = 1'b0;
         o_rsp_r = 1'b1;
         stepCycle();
         checkOutput("bp drained", 128'(o_rsp_v), 128'(0));
         checkOutput("perror sticky", 128'(o_perror), 128'(1));
      end

      // Reset while waiting for interrupt completion
      o_intr_r = 1'b1;
      i_intr_done_v = 1'b0;
      driveRsp(10'd77, goodEa(64'h77), 1'b1, 4'h5);
      stepCycle();
      i_rsp_v = 1'b0;
      stepCycle();
      checkOutput("in wait done_r", 128'(i_intr_done_r), 128'(1));
      reset = 1'b0;
      #1;
      checkResetOutputs("mid reset");
      stepCycle();
      reset = 1'b1;
      i_intr_done_v  = 1'b1;
      i_intr_done_rc = 2'd0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checkOutput($sformatf("stale done held %0d", k), 128'(i_intr_done_r), 128'(0));
         stepCycle();
      end
      applyStimulus(vecs[1], 7);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ktms_afu_sintr.md
# ktms_afu_sintr

Response-stage interrupt sequencer that sits directly downstream of the IOASA writer. It consumes one command response at a time. For responses flagged for a synchronous interrupt, it issues an interrupt command to the PSL command path and waits for completion, retrying with backoff on failure. It then forwards the response toward the context completion logic, tagged with the final interrupt outcome.

## Interface
Parameters:
- ctxtid_width, 10, context id width including parity bit
- ea_width, 65, effective address width; bit ea_width-1 is odd parity over [0:ea_width-2]
- tstag_width, 1, timestamp tag width
- aux_width, 1, auxiliary response data width
- sintrid_width, 4, synchronous interrupt id width
- bkoff_cycles, 16, idle cycles between interrupt retries (≥2)

Ports:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- i_rtry_cfg  in  6  max interrupt retries; 0 = no retry
- i_rsp_v / i_rsp_r  in / out  1 / 1  response handshake
- i_rsp_ctxt, i_rsp_ea, i_rsp_tstag, i_rsp_aux  in  ctxtid_width, ea_width, tstag_width, aux_width  response payload
- i_rsp_ec, i_rsp_nocmpl  in  1 each  endian control; no-completion flag
- i_rsp_sintr_v, i_rsp_sintr_id  in  1, sintrid_width  interrupt request and id
- o_intr_v / o_intr_r  out / in  1 / 1  interrupt command handshake
- o_intr_ctxt, o_intr_id  out  ctxtid_width, sintrid_width  interrupt command payload
- i_intr_done_v / i_intr_done_r  in / out  1 / 1  interrupt completion handshake
- i_intr_done_rc  in  2  completion code; 0 = ok, nonzero = failed
- o_rsp_v / o_rsp_r  out / in  1 / 1  downstream response handshake
- o_rsp_ctxt, o_rsp_ea, o_rsp_tstag, o_rsp_aux, o_rsp_ec, o_rsp_nocmpl  out  same widths as inputs  registered copy of the response
- o_rsp_intr_fail  out  1  interrupt was required but exhausted its retries
- o_dbg_cnt_inc  out  2  [0] pulses once per interrupt issued (including retries); [1] pulses once per final failure
- o_perror  out  1  sticky EA parity error, registered

## Operation
- A single holding register plus an FSM with states IDLE, REQ, WAIT, BKOFF and OUT.
- **IDLE:**
  - i_rsp_r=1; on i_rsp_v, capture the payload and clear rtry_cnt.
  - If sintr_v=1, go to REQ; otherwise go to OUT.
- **REQ:**
  - o_intr_v=1 with the held ctxt and sintr_id.
  - On o_intr_r, pulse dbg[0] and go to WAIT.
- **WAIT:**
  - i_intr_done_r=1; it is 0 in every other state.
  - On done with rc=0, go to OUT with intr_fail=0.
  - On rc≠0 with rtry_cnt < i_rtry_cfg, increment rtry_cnt, load bkoff_cnt=bkoff_cycles-1 and go to BKOFF.
  - On rc≠0 with rtry_cnt ≥ i_rtry_cfg, pulse dbg[1] and go to OUT with intr_fail=1.
- **BKOFF:**
  - Decrement bkoff_cnt; when it reaches 0, go to REQ.
- **OUT:**
  - o_rsp_v=1 with the held payload and intr_fail.
  - On o_rsp_r:
    - if i_rsp_v is also asserted, capture the new response (i_rsp_r = IDLE | (OUT & o_rsp_r)) and branch as in IDLE;
    - otherwise go to IDLE.
- rtry_cnt is 6 bits, compared unsigned; it cannot wrap because it is bounded by i_rtry_cfg.
- i_rtry_cfg is sampled live at each failure.
- **Parity:**
  - Check EA parity on every accepted response.
  - A mismatch sets the sticky error; o_perror is its registered copy (one cycle later).
  - It clears only on reset.
  - The response is still processed normally.
- An i_intr_done_v arriving outside WAIT is not accepted and stays pending until WAIT.

## Timing
- **Reset values (async, reset=0):** state=IDLE, all counters 0, o_rsp_v=0, o_intr_v=0, i_intr_done_r=0, o_rsp_intr_fail=0, o_dbg_cnt_inc=0, o_perror=0, payload register 0, i_rsp_r=1 once reset deasserts.
- **Bypass latency:** o_rsp_v is asserted the cycle after the accept. Sustained throughput is 1 response/cycle while o_rsp_r=1.
- **Interrupt path:** the minimum cycle sequence is accept → REQ → WAIT → OUT, assuming o_intr_r and done are each immediate. Each retry adds bkoff_cycles cycles plus the REQ and WAIT cycles.
- Valid and payload stay stable until their handshake; no output changes combinationally from the ready inputs.
- **Reset mid-operation:** the in-flight response and interrupt are dropped. A later stale i_intr_done_v is held off until WAIT.

## Structure
- Shared package ktms_sintr_pkg holds:
  - the FSM state enum;
  - INTR_RC_OK=2'd0;
  - the default BKOFF constant.
- The backoff/retry counter pair is natural as one sub-module, ktms_afu_rtry_ctr, with load, decrement and increment controls and zero/limit flags.
- Parity checking reuses the existing capi_parcheck.

## Test plan
- **Bypass stream:** 4 back-to-back responses with sintr_v=0 and o_rsp_r=1 → 4 outputs on consecutive cycles, latency 1, intr_fail=0, o_intr_v never asserted.
- **Single interrupt:** sintr_v=1, id=4'h3, ctxt=10, done rc=0 on first try → exactly one o_intr with id 3 and ctxt 10, dbg[0] pulses once, o_rsp with intr_fail=0.
- **Retry then succeed:** i_rtry_cfg=2, rc sequence 1, 0 → two interrupts separated by ≥16 idle cycles, intr_fail=0, dbg[1] never pulses.
- **Retry exhaustion:** i_rtry_cfg=0, rc=2 → one interrupt, dbg[1] pulses, o_rsp_intr_fail=1. With i_rtry_cfg=3 and rc always 1 → 4 interrupts then fail.
- **Backpressure and parity:** hold o_rsp_r=0 for 10 cycles with a bad-parity EA → payload stable, i_rsp_r=0, o_perror=1 one cycle after the accept and still 1 after the response drains.
- **Reset in WAIT:** assert reset → all outputs at reset values immediately. A done pulse after reset is not accepted until a new interrupt reaches WAIT.
